calc_operand_sequencer: RTL and testbench
=========================================

Name: calc_operand_sequencer

Overview:
Front-end control stage of the calculator datapath. It collects operand A, operand B and the opcode from the switch bank, one press of the enter button at a time, and drives them as registered values into the combinational ALU. It then captures the ALU result and error flag into holding registers. It also supplies the value to show on the display and a status code to the LEDs.

Parameters:
WIDTH, 16, operand/result width; must match the ALU (16).
OP_WIDTH, 2, opcode width (0 add, 1 sub, 2 and, 3 or).
SYNC_STAGES, 2, flip-flops in the enter-button synchronizer (≥2).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
data_in  in  WIDTH  switch bank value (asynchronous to clk, quasi-static).
enter  in  1  debounced enter button level, asynchronous.
clear  in  1  synchronous clear, active-high, already synchronized.
alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_op.
alu_error  in  1  ALU carry/borrow flag.
alu_a  out  WIDTH  registered operand A to ALU.
alu_b  out  WIDTH  registered operand B to ALU.
alu_op  out  OP_WIDTH  registered opcode to ALU.
result  out  WIDTH  latched ALU result.
error  out  1  latched ALU error.
display_value  out  WIDTH  value for the 7-segment driver.
state_code  out  3  current state encoding, for the LEDs.

Behaviour:
- Reset (reset_n low, asynchronous): state WAIT_A; all registered outputs 0 (alu_a, alu_b, alu_op, result, error); synchronizer and edge flops 0.
- Enter path:
  - enter passes through SYNC_STAGES flops, then one more flop (prev).
  - enter_pulse = sync_out & ~prev, exactly one cycle per press.
  - Holding enter produces no repeat pulses.
  - Register/state update occurs SYNC_STAGES rising edges after the edge that first samples enter high.
- States (state_code value):
  - WAIT_A (0): on enter_pulse, alu_a <= data_in; go to WAIT_B.
  - WAIT_B (1): on enter_pulse, alu_b <= data_in; go to WAIT_OP.
  - WAIT_OP (2): on enter_pulse, alu_op <= data_in[OP_WIDTH-1:0]; go to EXEC.
  - EXEC (3): exactly one cycle; ALU inputs are already stable; result <= alu_result, error <= alu_error; go to SHOW unconditionally.
  - SHOW (4): hold all registers; on enter_pulse go to WAIT_A. alu_a/alu_b/alu_op/result/error are retained until overwritten.
  - Codes 5–7 are unreachable; if entered, go to WAIT_A next cycle with no register change.
- clear: highest synchronous priority. In any state it sets state WAIT_A and zeroes alu_a, alu_b, alu_op, result and error in the same edge. An enter_pulse in that cycle is ignored.
- display_value is combinational from state:
  - WAIT_A/WAIT_B: data_in (live preview).
  - WAIT_OP: data_in[OP_WIDTH-1:0] zero-extended.
  - EXEC: alu_result.
  - SHOW: result.
- result and error change only in EXEC or on clear/reset. A switch change in SHOW does not alter result.
- Reset asserted mid-sequence aborts it. There is no partial-state retention.
- Overall latency: the third press's sampling edge + SYNC_STAGES + 1 edge gives valid result/error in SHOW.

Test Plan:
1. Reset, then presses with data_in=0x0005, 0x0003, 0x0000 -> alu_a=0x0005, alu_b=0x0003, alu_op=0; in SHOW, result=0x0008, error=0, state_code=4, display_value=0x0008.
2. A=0xFFFF, B=0x0001, OP=0 -> result=0x0000, error=1; then A=0x0003, B=0x0005, OP=1 -> result=0xFFFE, error=1.
3. A=0x00F0, B=0x0FFF, OP=2 -> result=0x00F0, error=0; repeat with OP=3 -> result=0x0FFF, error=0.
4. Hold enter high for 50 cycles in WAIT_A with data_in=0x1234 -> exactly one transition to WAIT_B, alu_a=0x1234, state stays 1.
5. In WAIT_OP, assert clear and a press-driven enter_pulse in the same cycle -> state_code=0, alu_a=alu_b=0, alu_op=0, result=0, error=0.
6. In SHOW with result=0x0008, pulse reset_n low mid-cycle -> all outputs 0 immediately (asynchronously), state_code=0. Separately, changing data_in in SHOW leaves result unchanged.

Source files
------------

// File: rtl/calc_operand_sequencer.sv
// Calculator front-end: gathers A, B and opcode on enter presses,
// drives the ALU, then latches the result and error flag.
module calc_operand_sequencer #(
  parameter int WIDTH       = 16,
  parameter int OP_WIDTH    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                enter,
  input  logic                clear,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_error,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    result,
  output logic                error,
  output logic [WIDTH-1:0]    display_value,
  output logic [2:0]          state_code
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   enter_pulse;

  // enter is asynchronous; the last sync flop feeds the edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], enter};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign enter_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= WAIT_A;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
      error  <= 1'b0;
    end else if (clear) begin
      state  <= WAIT_A;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      unique case (state)
        WAIT_A: begin
          if (enter_pulse) begin
            alu_a <= data_in;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_pulse) begin
            alu_b <= data_in;
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (enter_pulse) begin
            alu_op <= data_in[OP_WIDTH-1:0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_result;
          error  <= alu_error;
          state  <= SHOW;
        end
        SHOW: begin
          if (enter_pulse) begin
            state <= WAIT_A;
          end
        end
        default: begin
          state <= WAIT_A;
        end
      endcase
    end
  end

  always_comb begin
    display_value = '0;
    unique case (state)
      WAIT_A,
      WAIT_B: begin
        display_value = data_in;
      end
      WAIT_OP: begin
        display_value = {{(WIDTH-OP_WIDTH){1'b0}},
                         data_in[OP_WIDTH-1:0]};
      end
      EXEC: begin
        display_value = alu_result;
      end
      SHOW: begin
        display_value = result;
      end
      default: begin
        display_value = '0;
      end
    endcase
  end

  assign state_code = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Randomized scoreboard bench for calc_operand_sequencer with a
// behavioural ALU stand-in and a reference model of the calculator.
module tb_calc_operand_sequencer;

  logic        clk;
  logic        reset_n;
  logic [15:0] data_in;
  logic        enter;
  logic        clear;
  logic [15:0] alu_result;
  logic        alu_error;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] result;
  logic        error;
  logic [15:0] display_value;
  logic [2:0]  state_code;

  calc_operand_sequencer #(
    .WIDTH(16),
    .OP_WIDTH(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .enter(enter),
    .clear(clear),
    .alu_result(alu_result),
    .alu_error(alu_error),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .result(result),
    .error(error),
    .display_value(display_value),
    .state_code(state_code)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   shows = 0;
  int   mstate = 0;
  logic [2:0] last_code = 3'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ALU stand-in: the real combinational ALU sits outside this block
  always_comb begin
    logic [16:0] t;
    t = 17'd0;
    case (alu_op)
      2'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
      2'd2: t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, alu_a | alu_b};
    endcase
    alu_result = t[15:0];
    alu_error  = t[16];
  end

  function automatic exp_t ref_calc(input int a, input int b,
                                    input int op);
    exp_t e;
    int   v;
    e.a  = a[15:0];
    e.b  = b[15:0];
    e.op = op[1:0];
    e.err = 1'b0;
    case (op)
      0: begin
        v = a + b;
        e.err = (v > 65535);
        v = v % 65536;
      end
      1: begin
        v = a - b;
        e.err = (v < 0);
        if (v < 0) v = v + 65536;
      end
      2: v = a & b;
      default: v = a | b;
    endcase
    e.res = v[15:0];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every entry into SHOW must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && state_code == 3'd3 && sb.size() > 0)
      check("exec_display", display_value, sb[0].res);
    if (reset_n && state_code == 3'd4 && last_code == 3'd3) begin
      shows++;
      if (sb.size() == 0) begin
        check("show_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_alu_a", alu_a, e.a);
        check("sb_alu_b", alu_b, e.b);
        check("sb_alu_op", alu_op, e.op);
        check("sb_result", result, e.res);
        check("sb_error", error, e.err);
        check("sb_display", display_value, e.res);
      end
    end
    last_code = state_code;
  end

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (state_code !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, state_code, s);
  endtask

  task automatic press(input logic [15:0] v, input int hold);
    @(negedge clk);
    data_in = v;
    #1;
    if (mstate == 0 || mstate == 1)
      check("preview", display_value, v);
    else if (mstate == 2)
      check("preview_op", display_value, {14'd0, v[1:0]});
    enter = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    mstate = (mstate == 2) ? 4 : (mstate == 4) ? 0 : mstate + 1;
  endtask

  task automatic run_seq(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] op_raw, input int hold_a,
                         input bit stay);
    exp_t e;
    e = ref_calc(int'(a), int'(b), int'(op_raw[1:0]));
    sb.push_back(e);
    pushed++;
    if (hold_a > 10) begin
      @(negedge clk);
      data_in = a;
      enter = 1'b1;
      repeat (hold_a) @(negedge clk);
      check("hold_state", state_code, 3'd1);
      check("hold_alu_a", alu_a, a);
      enter = 1'b0;
      repeat (4) @(negedge clk);
      check("hold_release", state_code, 3'd1);
      mstate = 1;
    end else begin
      press(a, 3);
    end
    press(b, 3);
    press(op_raw, 3);
    wait_state(3'd4, "show_reach");
    data_in = ~data_in;
    repeat (2) @(negedge clk);
    check("show_keep_result", result, e.res);
    check("show_keep_error", error, e.err);
    if (!stay) begin
      press(16'h0000, 3);
      check("back_to_a", state_code, 3'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = 16'h0;
    enter   = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_code, 3'd0);
    check("rst_outs", {alu_a, alu_b, alu_op, result, error},
          {16'h0, 16'h0, 2'd0, 16'h0, 1'b0});
    reset_n = 1'b1;
    @(negedge clk);

    run_seq(16'h0005, 16'h0003, 16'h0000, 3, 1'b0);
    run_seq(16'hFFFF, 16'h0001, 16'h0000, 3, 1'b0);
    run_seq(16'h0003, 16'h0005, 16'h0001, 3, 1'b0);
    run_seq(16'h00F0, 16'h0FFF, 16'h0002, 3, 1'b0);
    run_seq(16'h00F0, 16'h0FFF, 16'h0003, 3, 1'b0);
    run_seq(16'h1234, 16'h4321, 16'hABC1, 50, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] ro;
      ra = 16'($urandom);
      rb = 16'($urandom);
      ro = 16'($urandom);
      run_seq(ra, rb, ro, 2 + int'($urandom_range(0, 4)), 1'b0);
    end

    // clear coinciding with the enter pulse in WAIT_OP
    press(16'h1111, 3);
    press(16'h2222, 3);
    check("pre_clear_state", state_code, 3'd2);
    @(negedge clk);
    data_in = 16'h0003;
    enter = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check("clear_state", state_code, 3'd0);
    check("clear_outs", {alu_a, alu_b, alu_op, result, error},
          {16'h0, 16'h0, 2'd0, 16'h0, 1'b0});
    repeat (4) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    check("clear_no_replay", state_code, 3'd0);
    mstate = 0;

    // asynchronous reset while showing a result
    run_seq(16'h0005, 16'h0003, 16'h0000, 3, 1'b1);
    check("pre_rst_result", result, 16'h0008);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", state_code, 3'd0);
    check("async_rst_outs", {alu_a, alu_b, alu_op, result, error},
          {16'h0, 16'h0, 2'd0, 16'h0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    mstate = 0;
    run_seq(16'h8000, 16'h8000, 16'h0000, 3, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("show_count", shows, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
